// File: rtl/projectile_unit.sv
// projectile_unit: one-shell projectile with key-edge fire, flight, hit detect and off-screen end.
// Optional re-fire lockout state is built only when BULLET_COOLDOWN_EN is defined.
module projectile_unit #(
    parameter logic [7:0] FIRE_KEY        = 8'h2C,
    parameter int         SPEED           = 4,
    parameter int         HIT_R           = 8,
    parameter int         X_MAX           = 639,
    parameter int         Y_MAX           = 479,
    parameter int         COOLDOWN_FRAMES = 30
) (
    input  logic        frame_clk,
    input  logic        Reset_n,
    input  logic [31:0] keycode,
    input  logic [9:0]  tank_x,
    input  logic [9:0]  tank_y,
    input  logic [1:0]  tank_dir,
    input  logic [9:0]  target_x,
    input  logic [9:0]  target_y,
    input  logic        game_over,
    output logic        shot_hit,
    output logic [9:0]  bullet_x,
    output logic [9:0]  bullet_y,
    output logic        bullet_active
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FLIGHT   = 2'd1;
    localparam logic [1:0] HIT      = 2'd2;
    localparam logic [1:0] COOLDOWN = 2'd3;

    localparam logic [10:0] STEP = 11'(SPEED);
    localparam logic [10:0] R    = 11'(HIT_R);
    localparam logic [10:0] XM   = 11'(X_MAX);
    localparam logic [10:0] YM   = 11'(Y_MAX);

`ifdef BULLET_COOLDOWN_EN
    localparam logic [1:0] END_STATE = COOLDOWN;
    localparam int CW = $clog2(COOLDOWN_FRAMES + 2);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    localparam logic [1:0] END_STATE = IDLE;
`endif

    logic [1:0]  state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic [9:0]  bullet_x_q, bullet_x_d;
    logic [9:0]  bullet_y_q, bullet_y_d;
    logic        shot_hit_q, shot_hit_d;
    logic        bullet_active_q, bullet_active_d;
    logic        key_prev_q, key_seen_q;
    logic        key_now, fire;
    logic [10:0] bx, by, tx, ty, dx, dy, nx, ny;
    logic        hit, oob;

    assign key_now = (keycode[7:0] == FIRE_KEY) || (keycode[15:8] == FIRE_KEY) ||
                     (keycode[23:16] == FIRE_KEY) || (keycode[31:24] == FIRE_KEY);
    // key_seen_q masks the first cycle after reset so a key held through reset is not an edge
    assign fire = key_now && !key_prev_q && key_seen_q;

    assign bx  = {1'b0, bullet_x_q};
    assign by  = {1'b0, bullet_y_q};
    assign tx  = {1'b0, target_x};
    assign ty  = {1'b0, target_y};
    assign dx  = (bx >= tx) ? bx - tx : tx - bx;
    assign dy  = (by >= ty) ? by - ty : ty - by;
    assign hit = (dx <= R) && (dy <= R);
    assign nx  = (dir_q == 2'd1) ? bx + STEP : (dir_q == 2'd3) ? bx - STEP : bx;
    assign ny  = (dir_q == 2'd2) ? by + STEP : (dir_q == 2'd0) ? by - STEP : by;
    assign oob = ((dir_q == 2'd1) && (nx > XM)) || ((dir_q == 2'd3) && (bx < STEP)) ||
                 ((dir_q == 2'd2) && (ny > YM)) || ((dir_q == 2'd0) && (by < STEP));

    always_comb begin
        state_d         = state_q;
        dir_d           = dir_q;
        bullet_x_d      = bullet_x_q;
        bullet_y_d      = bullet_y_q;
        shot_hit_d      = 1'b0;
        bullet_active_d = bullet_active_q;
`ifdef BULLET_COOLDOWN_EN
        cnt_d           = cnt_q;
`endif
        if (game_over) begin
            state_d         = IDLE;
            bullet_active_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        state_d         = FLIGHT;
                        bullet_x_d      = tank_x;
                        bullet_y_d      = tank_y;
                        dir_d           = tank_dir;
                        bullet_active_d = 1'b1;
                    end
                end
                FLIGHT: begin
                    if (hit) begin
                        state_d         = HIT;
                        shot_hit_d      = 1'b1;
                        bullet_active_d = 1'b0;
                    end else if (oob) begin
                        state_d         = END_STATE;
                        bullet_active_d = 1'b0;
`ifdef BULLET_COOLDOWN_EN
                        cnt_d           = '0;
`endif
                    end else begin
                        bullet_x_d = nx[9:0];
                        bullet_y_d = ny[9:0];
                    end
                end
                HIT: begin
                    state_d = END_STATE;
`ifdef BULLET_COOLDOWN_EN
                    cnt_d   = '0;
`endif
                end
                default: begin
`ifdef BULLET_COOLDOWN_EN
                    if (int'(cnt_q) + 1 >= COOLDOWN_FRAMES) state_d = IDLE;
                    else cnt_d = cnt_q + 1'b1;
`else
                    state_d = IDLE;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q         <= IDLE;
            dir_q           <= 2'd0;
            bullet_x_q      <= 10'd0;
            bullet_y_q      <= 10'd0;
            shot_hit_q      <= 1'b0;
            bullet_active_q <= 1'b0;
            key_prev_q      <= 1'b0;
            key_seen_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            dir_q           <= dir_d;
            bullet_x_q      <= bullet_x_d;
            bullet_y_q      <= bullet_y_d;
            shot_hit_q      <= shot_hit_d;
            bullet_active_q <= bullet_active_d;
            key_prev_q      <= key_now;
            key_seen_q      <= 1'b1;
        end
    end

`ifdef BULLET_COOLDOWN_EN
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`endif

    assign shot_hit      = shot_hit_q;
    assign bullet_x      = bullet_x_q;
    assign bullet_y      = bullet_y_q;
    assign bullet_active = bullet_active_q;

endmodule

// File: tb/tb_projectile_unit.sv
// tb_projectile_unit: randomized scoreboard bench; a trajectory model queues the expected outputs,
// and a negedge monitor pops one entry for every cycle the unit shows a live or hitting shell.
module tb_projectile_unit;

    logic        frame_clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] keycode = '0;
    logic [9:0]  tank_x = '0, tank_y = '0, target_x = '0, target_y = '0;
    logic [1:0]  tank_dir = '0;
    logic        game_over = 1'b0;
    logic        shot_hit, bullet_active;
    logic [9:0]  bullet_x, bullet_y;

`ifdef BULLET_COOLDOWN_EN
    localparam int CD = 30;
`else
    localparam int CD = 0;
`endif

    typedef struct {int x; int y; bit hit;} samp_t;
    samp_t exp_q[$];
    samp_t mon_s;
    int n_cmp = 0, n_bad = 0;

    projectile_unit dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode),
        .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir),
        .target_x(target_x), .target_y(target_y), .game_over(game_over),
        .shot_hit(shot_hit), .bullet_x(bullet_x), .bullet_y(bullet_y),
        .bullet_active(bullet_active)
    );

    always #5 frame_clk = ~frame_clk;

    always @(negedge frame_clk) begin
        if (Reset_n && (bullet_active || shot_hit)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got x=%0d y=%0d active=%0b hit=%0b, required no output",
                         bullet_x, bullet_y, bullet_active, shot_hit);
            end else begin
                mon_s = exp_q.pop_front();
                if (int'(bullet_x) != mon_s.x || int'(bullet_y) != mon_s.y ||
                    shot_hit != mon_s.hit || bullet_active != !mon_s.hit) begin
                    n_bad++;
                    $display("FAIL sample: got x=%0d y=%0d active=%0b hit=%0b, required x=%0d y=%0d active=%0b hit=%0b",
                             bullet_x, bullet_y, bullet_active, shot_hit, mon_s.x, mon_s.y, !mon_s.hit, mon_s.hit);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    // A shell appears at the tank, then each frame either hits, leaves the screen, or moves 4 px.
    task automatic plan(input int x0, input int y0, input int dir, input int tx, input int ty, output int n);
        int x = x0, y = y0, nx, ny;
        exp_q.push_back('{x, y, 1'b0});
        n = 1;
        forever begin
            if (iabs(x - tx) <= 8 && iabs(y - ty) <= 8) begin
                exp_q.push_back('{x, y, 1'b1});
                n++;
                break;
            end
            nx = x + (dir == 1 ? 4 : dir == 3 ? -4 : 0);
            ny = y + (dir == 2 ? 4 : dir == 0 ? -4 : 0);
            if (nx < 0 || nx > 639 || ny < 0 || ny > 479) break;
            x = nx;
            y = ny;
            exp_q.push_back('{x, y, 1'b0});
            n++;
        end
    endtask

    function automatic logic [31:0] keys(input bit press);
        logic [31:0] k;
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h2C) b = 8'h00;
            k[i*8 +: 8] = b;
        end
        if (press) k[$urandom_range(0, 3)*8 +: 8] = 8'h2C;
        return k;
    endfunction

    task automatic run_shot(input int x0, input int y0, input int dir, input int tx, input int ty,
                            input int hold, input bit rp_en);
        int n, rp, total;
        tank_x = 10'(x0); tank_y = 10'(y0); tank_dir = 2'(dir);
        target_x = 10'(tx); target_y = 10'(ty);
        plan(x0, y0, dir, tx, ty, n);
        rp = (rp_en && n - 1 >= hold + 1) ? $urandom_range(hold + 1, n - 1) : -1;
        total = (n > hold ? n : hold) + (rp + 2) + CD + 4;
        for (int c = 0; c < total; c++) begin
            keycode = keys(c < hold || c == rp);
            @(posedge frame_clk) #2;
        end
        keycode = keys(1'b0);
        check("drain", exp_q.size(), 0);
    endtask

    int dir, x0, y0, tx, ty, d;

    initial begin
        repeat (2) @(posedge frame_clk);
        #3;
        check("rst_active", bullet_active, 0);
        check("rst_hit", shot_hit, 0);
        check("rst_x", bullet_x, 0);
        check("rst_y", bullet_y, 0);
        @(posedge frame_clk) #2;
        Reset_n = 1'b1;
        repeat (2) @(posedge frame_clk);
        #2;

        run_shot(100, 100, 1, 140, 100, 1, 1'b0);
        run_shot(630, 50, 1, 1000, 1000, 3, 1'b0);
        run_shot(200, 200, 2, 900, 900, 20, 1'b0);
        run_shot(200, 100, 1, 600, 100, 2, 1'b1);
        run_shot(0, 0, 3, 500, 500, 1, 1'b0);
        run_shot(320, 240, 0, 320, 240, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            dir = $urandom_range(0, 3);
            x0 = $urandom_range(0, 639);
            y0 = $urandom_range(0, 479);
            d = $urandom_range(0, 200);
            tx = x0 + (dir == 1 ? d : dir == 3 ? -d : $urandom_range(0, 20) - 10);
            ty = y0 + (dir == 2 ? d : dir == 0 ? -d : $urandom_range(0, 20) - 10);
            if ($urandom_range(0, 1) == 0 || tx < 0 || tx > 1023 || ty < 0 || ty > 1023) begin
                tx = $urandom_range(0, 1023);
                ty = $urandom_range(0, 1023);
            end
            run_shot(x0, y0, dir, tx, ty, $urandom_range(1, 20), 1'($urandom_range(0, 1)));
        end

        // reset mid-flight with the fire key held through release
        tank_x = 10'd300; tank_y = 10'd200; tank_dir = 2'd1; target_x = 10'd1000; target_y = 10'd1000;
        plan(300, 200, 1, 1000, 1000, d);
        keycode = keys(1'b1);
        repeat (5) @(posedge frame_clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_rst_active", bullet_active, 0);
        check("async_rst_x", bullet_x, 0);
        check("async_rst_y", bullet_y, 0);
        check("async_rst_hit", shot_hit, 0);
        exp_q.delete();
        repeat (2) @(posedge frame_clk);
        #2;
        Reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            keycode = keys(1'b1);
            @(posedge frame_clk) #2;
        end
        keycode = keys(1'b0);
        repeat (3) @(posedge frame_clk);
        #2;
        check("no_refire_after_rst", exp_q.size(), 0);

        // game_over during flight, then key edges while frozen
        tank_x = 10'd100; tank_y = 10'd300; tank_dir = 2'd3; target_x = 10'd900; target_y = 10'd900;
        plan(100, 300, 3, 900, 900, d);
        keycode = keys(1'b1);
        @(posedge frame_clk) #2;
        keycode = keys(1'b0);
        repeat (4) @(posedge frame_clk);
        #2;
        game_over = 1'b1;
        @(posedge frame_clk) #2;
        check("gameover_active", bullet_active, 0);
        check("gameover_hit", shot_hit, 0);
        exp_q.delete();
        for (int c = 0; c < 8; c++) begin
            keycode = keys(c[0]);
            @(posedge frame_clk) #2;
        end
        keycode = keys(1'b0);
        @(posedge frame_clk) #2;
        game_over = 1'b0;
        repeat (4) @(posedge frame_clk);
        #2;
        check("gameover_frozen", exp_q.size(), 0);
        run_shot(400, 400, 0, 400, 100, 1, 1'b0);

`ifdef BULLET_COOLDOWN_EN
        // hit at frame n; a key edge 10 frames later is locked out, 31 frames later it fires
        tank_x = 10'd100; tank_y = 10'd100; tank_dir = 2'd1; target_x = 10'd140; target_y = 10'd100;
        plan(100, 100, 1, 140, 100, d);
        for (int c = 0; c < d + 31 + 20; c++) begin
            if (c == d + 31) plan(100, 100, 1, 140, 100, x0);
            keycode = keys(c == 0 || c == d + 10 || c == d + 31);
            @(posedge frame_clk) #2;
        end
        keycode = keys(1'b0);
        check("cooldown_drain", exp_q.size(), 0);
`endif

        repeat (3) @(posedge frame_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/projectile_unit.md
PROJECTILE_UNIT -- requirements
Module: projectile_unit

Interface
REQ-001 SHALL have parameter FIRE_KEY, default 8'h2C, keyboard scancode that fires this player's shell.
REQ-002 SHALL have parameter SPEED, default 4, pixels moved per frame_clk cycle.
REQ-003 SHALL have parameter HIT_R, default 8, half-width of the square hit box, in pixels.
REQ-004 SHALL have parameter X_MAX, default 639, and parameter Y_MAX, default 479, the last on-screen pixel on each axis.
REQ-005 SHALL have parameter COOLDOWN_FRAMES, default 30, the re-fire lockout in frames.
REQ-006 SHALL have port frame_clk, input, 1 bit: the only clock; all logic rises on it.
REQ-007 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port keycode, input, 32 bits: four 8-bit key slots, [7:0] to [31:24].
REQ-009 SHALL have ports tank_x and tank_y, inputs, 10 bits each: shooter position.
REQ-010 SHALL have port tank_dir, input, 2 bits: shooter heading; 0=up(-y), 1=right(+x), 2=down(+y), 3=left(-x).
REQ-011 SHALL have ports target_x and target_y, inputs, 10 bits each: opponent position.
REQ-012 SHALL have port game_over, input, 1 bit: level from game_sm; when high, firing is frozen.
REQ-013 SHALL have port shot_hit, output, 1 bit: one-cycle hit pulse, consumed by game_sm as shot_hit1 or shot_hit2.
REQ-014 SHALL have ports bullet_x and bullet_y, outputs, 10 bits each, and port bullet_active, output, 1 bit, for the renderer.

Function
REQ-015 SHALL detect a fire request when any keycode byte equals FIRE_KEY in the current cycle and no byte equalled it in the previous cycle (rising-edge detect).
REQ-016 SHALL implement states IDLE, FLIGHT and HIT, plus COOLDOWN when the Configuration macro is defined.
REQ-017 In IDLE, on a fire request with game_over=0, SHALL load bullet_x/y=tank_x/y, latch tank_dir, and enter FLIGHT; bullet_active=1 from the next cycle.
REQ-018 In FLIGHT, each cycle SHALL first test the hit condition |bullet_x-target_x|<=HIT_R and |bullet_y-target_y|<=HIT_R, using 11-bit unsigned differences; on a hit it SHALL enter HIT.
REQ-019 In FLIGHT, when there is no hit, SHALL advance one SPEED step in the latched direction.
REQ-020 In FLIGHT, if the step would go below 0 or above X_MAX/Y_MAX, SHALL instead end the flight with no hit.
REQ-021 In HIT, SHALL drive shot_hit=1 for exactly one cycle and set bullet_active=0, then leave HIT.
REQ-022 Fire requests in FLIGHT, HIT or COOLDOWN SHALL be ignored and SHALL not be queued; only one shell is live per unit.
REQ-023 game_over=1 SHALL force a return to IDLE from any state on the next edge, with bullet_active=0 and shot_hit=0.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 Reset_n=0 SHALL asynchronously force IDLE, shot_hit=0, bullet_active=0, bullet_x=0, bullet_y=0, cooldown count=0 and the key-edge history=0, including during FLIGHT.
REQ-026 After release, the first fire SHALL require a fresh key edge per REQ-015.

Configuration
REQ-027 With BULLET_COOLDOWN_EN defined, HIT and flight end SHALL enter COOLDOWN, which counts COOLDOWN_FRAMES cycles and then goes to IDLE.
REQ-028 Without BULLET_COOLDOWN_EN, HIT and flight end SHALL go directly to IDLE, and no counter SHALL be synthesized.

Verification
REQ-029 Tank (100,100), dir=1, target (140,100), key 8'h2C pressed -> bullet_x 100,104,...; shot_hit pulses one cycle when bullet_x=132; bullet_active then 0.
REQ-030 Tank (630,50), dir=1, target far away -> bullet reaches 638; next step would give 642, so flight ends, shot_hit stays 0, bullet_active=0.
REQ-031 Key held 20 cycles, or pressed again mid-flight -> exactly one shell fired, one flight only.
REQ-032 Reset_n driven low during FLIGHT -> outputs zero immediately, without a clock edge; a held key does not re-fire after release.
REQ-033 game_over=1 during FLIGHT -> next edge IDLE, bullet_active=0; key edges ignored while game_over=1.
REQ-034 With BULLET_COOLDOWN_EN and a hit followed by a key edge after 10 cycles -> ignored; a key edge after 31 cycles -> fires.
